// File: rtl/sb_arb_pkg.sv
// Shared types and helpers for the switchboard stream arbiter.
//   arb_state_e : arbiter FSM states (IDLE = free to arbitrate, LOCKED = packet in flight)
//   SB_DESTW    : default width of the switchboard dest field
//   next_ptr    : round-robin pointer advance with explicit wrap at n-1
package sb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_e;

    localparam int unsigned SB_DESTW = 32;

    // Explicit compare against n-1 so non-power-of-two N wraps correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sb_rr_pick.sv
// Combinational round-robin picker.
// Finds the first asserted request searching cyclically upward from ptr_i.
//   req_i        : request vector, one bit per input
//   ptr_i        : index with highest priority this cycle
//   gnt_onehot_o : one-hot grant (all zero when nothing requests)
//   gnt_idx_o    : binary index of the grant (0 when nothing requests)
//   any_o        : at least one request present
module sb_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_win;
    int unsigned    sum;

    always_comb begin
        // Doubling the vector lets a plain shift act as a rotate by ptr_i.
        req_dbl   = {req_i, req_i};
        req_win   = N'(req_dbl >> ptr_i);
        any_o     = |req_i;
        gnt_idx_o = '0;
        sum       = 32'd0;
        // Walk downward so the lowest rotated position (highest priority) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_win[i]) begin
                sum = 32'(ptr_i) + 32'(i);
                if (sum >= N) begin
                    sum = sum - N;
                end
                gnt_idx_o = IW'(sum);
            end
        end
        gnt_onehot_o = any_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/sb_stream_arbiter.sv
// Round-robin, packet-atomic arbiter merging N switchboard streams into one
// registered output stream. A grant is held from a packet's first beat to its
// last beat; between packets the next owner is picked cyclically from rr_ptr.
//   clk, rst              : clock, asynchronous active-high reset
//   in_data/dest/last     : per-input beat fields, input i at [i*W +: W]
//   in_valid / in_ready   : per-input handshake
//   out_data/dest/last    : registered output beat
//   out_valid / out_ready : output handshake
//   grant_idx             : input currently (or most recently) owning the output
//   busy                  : high while a multi-beat packet is in flight
// Optional: define SB_ARB_PKT_STATS_EN to add pkt_count (N x 32-bit per-input
// packet counters, wrapping).
module sb_stream_arbiter
    import sb_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 256,
    parameter int unsigned DESTW = SB_DESTW,
    localparam int unsigned IW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*DW-1:0]    in_data,
    input  logic [N*DESTW-1:0] in_dest,
    input  logic [N-1:0]       in_last,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [DW-1:0]      out_data,
    output logic [DESTW-1:0]   out_dest,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IW-1:0]      grant_idx,
    output logic               busy
`ifdef SB_ARB_PKT_STATS_EN
    ,
    output logic [N*32-1:0]    pkt_count
`endif
);

    arb_state_e        state_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     grant_q;
    logic              busy_q;

    logic [DW-1:0]     out_data_q;
    logic [DESTW-1:0]  out_dest_q;
    logic              out_last_q;
    logic              out_valid_q;

    logic [N-1:0]      pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              ld;
    logic              sel_valid;
    logic              accept;
    logic              sel_last;
    logic [IW-1:0]     sel_idx;

    sb_rr_pick #(
        .N (N)
    ) u_pick (
        .req_i        (in_valid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (pick_onehot),
        .gnt_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    always_comb begin
        ld = !out_valid_q || out_ready;
        if (state_q == LOCKED) begin
            sel_idx   = grant_q;
            sel_valid = in_valid[grant_q];
        end else begin
            sel_idx   = pick_idx;
            sel_valid = pick_any;
        end
        sel_last = in_last[sel_idx];
        accept   = sel_valid && ld && !rst;

        // While locked the owner is offered ready even through gaps in its valid.
        in_ready = '0;
        if (ld && !rst) begin
            in_ready = (state_q == LOCKED) ? (N'(1) << grant_q) : pick_onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                grant_q <= pick_idx;
                if (sel_last) begin
                    rr_ptr_q <= IW'(next_ptr(32'(pick_idx), N));
                end else begin
                    state_q <= LOCKED;
                    busy_q  <= 1'b1;
                end
            end else if (sel_last) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                rr_ptr_q <= IW'(next_ptr(32'(grant_q), N));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_data_q  <= in_data[sel_idx*DW +: DW];
            out_dest_q  <= in_dest[sel_idx*DESTW +: DESTW];
            out_last_q  <= sel_last;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;

`ifdef SB_ARB_PKT_STATS_EN
    logic [31:0] cnt_q [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= 32'd0;
            end
        end else if (accept && sel_last) begin
            cnt_q[sel_idx] <= cnt_q[sel_idx] + 32'd1;
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < N; i++) begin
            pkt_count[i*32 +: 32] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_sb_stream_arbiter.sv
// Self-checking bench for sb_stream_arbiter (N=4, DW=32, DESTW=32).
// Transaction queues per input feed the DUT; a packet-level reference model
// predicts ready, ownership and the registered output every cycle.
// dest of each generated beat is {src[7:0], packet_seq[15:0], beat_idx[7:0]}.
module tb_sb_stream_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DESTW = 32;
    localparam int IW    = 2;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [DESTW-1:0] dest;
        logic             last;
    } beat_t;

    logic               clk;
    logic               rst;
    logic [N*DW-1:0]    in_data;
    logic [N*DESTW-1:0] in_dest;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [DW-1:0]      out_data;
    logic [DESTW-1:0]   out_dest;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic [IW-1:0]      grant_idx;
    logic               busy;
`ifdef SB_ARB_PKT_STATS_EN
    logic [N*32-1:0]    pkt_count;
`endif

    sb_stream_arbiter #(
        .N     (N),
        .DW    (DW),
        .DESTW (DESTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef SB_ARB_PKT_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    beat_t q [N][$];
    bit    en [N];
    int    pkt_seq;
    logic [DESTW-1:0] out_log [$];

    // Reference model state (packet-level view of the arbiter).
    bit    m_locked;
    int    m_owner;
    int    m_rr;
    int    m_grant;
    bit    m_ov;
    beat_t m_out;
    int    m_cnt [N];

    task automatic reset_model();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_grant  = 0;
        m_ov     = 1'b0;
        m_out    = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            q[i].delete();
            en[i] = 1'b1;
        end
    endtask

    task automatic push_beat(input int src, input logic [DW-1:0] data, input int idx,
                             input bit last);
        beat_t b;
        b.data = data;
        b.dest = {8'(src), 16'(pkt_seq), 8'(idx)};
        b.last = last;
        q[src].push_back(b);
        if (last) pkt_seq++;
    endtask

    task automatic enq_pkt(input int src, input int len);
        for (int k = 0; k < len; k++) begin
            push_beat(src, $urandom, k, (k == len - 1));
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: entered and left just after a falling edge.
    task automatic step();
        logic [N-1:0] drv_valid;
        logic [N-1:0] exp_rdy;
        bit           ld;
        int           w;
        int           acc;
        int           c;
        beat_t        b;
        for (int i = 0; i < N; i++) begin
            if (en[i] && q[i].size() > 0) begin
                b = q[i][0];
                drv_valid[i] = 1'b1;
            end else begin
                b.data = $urandom;
                b.dest = $urandom;
                b.last = 1'($urandom_range(0, 1));
                drv_valid[i] = 1'b0;
            end
            in_data[i*DW +: DW]       = b.data;
            in_dest[i*DESTW +: DESTW] = b.dest;
            in_last[i]                = b.last;
        end
        in_valid = drv_valid;
        #1;
        ld      = !m_ov || out_ready;
        exp_rdy = '0;
        w       = -1;
        if (m_locked) begin
            if (ld) exp_rdy[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (w < 0 && drv_valid[c]) w = c;
            end
            if (w >= 0 && ld) exp_rdy[w] = 1'b1;
        end
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready at %0t: got %b expected %b", $time, in_ready, exp_rdy);
        end
        acc = -1;
        for (int i = 0; i < N; i++) begin
            if (drv_valid[i] && exp_rdy[i]) acc = i;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) out_log.push_back(out_dest);

        @(posedge clk);
        #1;
        if (acc >= 0) begin
            b     = q[acc].pop_front();
            m_out = b;
            m_ov  = 1'b1;
            if (!m_locked) m_grant = acc;
            if (b.last) begin
                m_locked = 1'b0;
                m_rr     = (acc == N - 1) ? 0 : acc + 1;
                m_cnt[acc]++;
            end else begin
                m_locked = 1'b1;
                m_owner  = acc;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        checks++;
        if (out_valid !== m_ov) begin
            failures++;
            $display("FAIL out_valid at %0t: got %b expected %b", $time, out_valid, m_ov);
        end
        checks++;
        if (out_data !== m_out.data || out_dest !== m_out.dest || out_last !== m_out.last) begin
            failures++;
            $display("FAIL out_beat at %0t: got %h/%h/%b expected %h/%h/%b", $time,
                     out_data, out_dest, out_last, m_out.data, m_out.dest, m_out.last);
        end
        checks++;
        if (busy !== m_locked || grant_idx !== IW'(m_grant)) begin
            failures++;
            $display("FAIL busy_grant at %0t: got busy=%b grant=%0d expected busy=%b grant=%0d",
                     $time, busy, grant_idx, m_locked, m_grant);
        end
        @(negedge clk);
    endtask

    task automatic run_until_empty(input int max_cycles);
        int n;
        n = 0;
        while ((!queues_empty() || m_ov) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (!queues_empty() || m_ov) begin
            failures++;
            $display("FAIL drain_timeout: got %0d cycles without draining, required < %0d",
                     n, max_cycles);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        out_log.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '0;
        in_data   = '0;
        in_dest   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== '0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_dest !== '0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got v=%b d=%h dest=%h l=%b expected all zero",
                     out_valid, out_data, out_dest, out_last);
        end
        checks++;
        if (busy !== 1'b0 || grant_idx !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b grant=%0d expected 0/0", busy, grant_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        step();
    endtask

    task automatic test_single_packet();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'h11;
        exp_d[1] = 32'h22;
        exp_d[2] = 32'h33;
        do_reset();
        push_beat(2, exp_d[0], 0, 1'b0);
        push_beat(2, exp_d[1], 1, 1'b0);
        push_beat(2, exp_d[2], 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || grant_idx !== 2'd2
                || busy !== (k < 2)) begin
                failures++;
                $display("FAIL single_beat%0d: got v=%b d=%h g=%0d busy=%b expected 1/%h/2/%b",
                         k, out_valid, out_data, grant_idx, busy, exp_d[k], (k < 2));
            end
        end
        // rr_ptr is now 3: input 3 must beat input 0 when both request.
        push_beat(0, 32'hA0, 0, 1'b1);
        push_beat(3, 32'hA3, 0, 1'b1);
        step();
        checks++;
        if (out_dest[31:24] !== 8'd3) begin
            failures++;
            $display("FAIL single_rr_next: got src %0d expected 3", out_dest[31:24]);
        end
        run_until_empty(20);
    endtask

    task automatic test_fairness();
        int exp_src [10];
        int n;
        exp_src = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        enq_pkt(0, 2);
        enq_pkt(0, 2);
        for (int i = 1; i < N; i++) enq_pkt(i, 2);
        n = 0;
        while (!queues_empty() && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL fair_throughput: got %0d cycles expected 10", n);
        end
        run_until_empty(10);
        checks++;
        if (out_log.size() != 10) begin
            failures++;
            $display("FAIL fair_count: got %0d beats expected 10", out_log.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (out_log[k][31:24] !== 8'(exp_src[k]) || out_log[k][7:0] !== 8'(k % 2)
                    || (k % 2 == 1 && out_log[k][23:8] !== out_log[k-1][23:8])) begin
                    failures++;
                    $display("FAIL fair_order%0d: got dest %h expected src %0d beat %0d",
                             k, out_log[k], exp_src[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        enq_pkt(0, 1);
        run_until_empty(10);
        out_log.delete();
        enq_pkt(1, 2);
        enq_pkt(0, 2);
        step();
        en[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            checks++;
            if (busy !== 1'b1 || in_ready[0] !== 1'b0 || grant_idx !== 2'd1) begin
                failures++;
                $display("FAIL gap_hold%0d: got busy=%b rdy0=%b grant=%0d expected 1/0/1",
                         k, busy, in_ready[0], grant_idx);
            end
        end
        en[1] = 1'b1;
        run_until_empty(20);
        checks++;
        if (out_log.size() != 4 || out_log[0][31:24] !== 8'd1 || out_log[1][31:24] !== 8'd1
            || out_log[2][31:24] !== 8'd0 || out_log[3][31:24] !== 8'd0) begin
            failures++;
            $display("FAIL gap_order: got %0d beats, expected sources 1,1,0,0", out_log.size());
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] first;
        do_reset();
        enq_pkt(0, 3);
        first     = q[0][0].data;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== first || in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: got v=%b d=%h rdy0=%b expected 1/%h/0",
                     out_valid, out_data, in_ready[0], first);
        end
        out_ready = 1'b1;
        run_until_empty(20);
        checks++;
        if (out_log.size() != 3 || out_log[0][7:0] !== 8'd0 || out_log[1][7:0] !== 8'd1
            || out_log[2][7:0] !== 8'd2) begin
            failures++;
            $display("FAIL bp_sequence: got %0d beats expected 3 in order", out_log.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enq_pkt(1, 1);
        step();
        enq_pkt(2, 4);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== '0) begin
            failures++;
            $display("FAIL rst_mid: got v=%b busy=%b rdy=%b expected 0/0/0000",
                     out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        enq_pkt(3, 1);
        enq_pkt(0, 1);
        step();
        checks++;
        if (out_dest[31:24] !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_regrant: got src %0d expected 0", out_dest[31:24]);
        end
        run_until_empty(10);
    endtask

    task automatic test_random();
        int src;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                src = $urandom_range(0, N - 1);
                if (q[src].size() < 12) enq_pkt(src, $urandom_range(1, 4));
            end
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        out_ready = 1'b1;
        run_until_empty(300);
    endtask

`ifdef SB_ARB_PKT_STATS_EN
    task automatic test_stats();
        int exp_cnt [N];
        exp_cnt = '{1, 0, 0, 3};
        do_reset();
        for (int k = 0; k < 3; k++) enq_pkt(3, 2);
        enq_pkt(0, 1);
        run_until_empty(40);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pkt_count[i*32 +: 32] !== 32'(exp_cnt[i])) begin
                failures++;
                $display("FAIL stats_cnt%0d: got %0d expected %0d",
                         i, pkt_count[i*32 +: 32], exp_cnt[i]);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        pkt_seq  = 0;
        test_reset();
        test_single_packet();
        test_fairness();
        test_gap();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef SB_ARB_PKT_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
